icache_mem_arb: RTL and testbench
=================================

ICACHE_MEM_ARB -- requirements
Module: icache_mem_arb

Interface
REQ-001 SHALL have parameter NUM_MEM_TAGS, default 16, meaning the number of memory tags (tag 0 is reserved as "none").
REQ-002 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports proc2Imem_command1 / proc2Imem_command  input  2  icache port 1 / port 0 bus command (BUS_NONE=0, BUS_LOAD=1).
REQ-005 SHALL have ports proc2Imem_addr1 / proc2Imem_addr  input  64  icache port 1 / port 0 block address (8-byte aligned).
REQ-006 SHALL have ports Imem2proc_response1 / Imem2proc_response  output  4  accepted tag returned to port 1 / port 0 (0 means not accepted).
REQ-007 SHALL have ports Imem2proc_tag1 / Imem2proc_tag  output  4  data-return tag routed to port 1 / port 0.
REQ-008 SHALL have ports Imem2proc_data1 / Imem2proc_data  output  64  data routed to port 1 / port 0.
REQ-009 SHALL have port proc2mem_command  output  2  single memory-bus command.
REQ-010 SHALL have port proc2mem_addr  output  64  single memory-bus address.
REQ-011 SHALL have ports mem2proc_response  input  4, mem2proc_tag  input  4, mem2proc_data  input  64, all from memory.
REQ-012 SHALL have port outstanding_cnt  output  5  number of valid tag-table entries.

Function
REQ-013 Request arbitration SHALL be combinational: same-cycle proc2mem_command/addr carry the granted port's command/address, or BUS_NONE and 0 when neither port requests.
REQ-014 A port is requesting when its command != BUS_NONE; a non-granted port SHALL see response 0 and hold its request.
REQ-015 The granted port's response output SHALL equal mem2proc_response in the same cycle.
REQ-016 Merge: when both ports request with equal addresses, the arbiter SHALL issue once, and both response outputs SHALL equal mem2proc_response.
REQ-017 The tag table holds NUM_MEM_TAGS entries, each with a 2-bit owner mask; entry 0 is never valid.
REQ-018 On posedge with mem2proc_response != 0, entry[mem2proc_response] SHALL be set to the owner mask of the granted port(s).
REQ-019 When mem2proc_tag != 0 and its entry is valid, the arbiter SHALL drive mem2proc_tag and mem2proc_data combinationally to every owner, drive 0 to non-owners, and clear the entry on posedge.
REQ-020 A returning tag with an invalid entry SHALL be dropped: both tag outputs 0, and no state change.
REQ-021 When a tag is freed and allocated in the same cycle, the allocation SHALL win, and the entry ends valid with the new owner.
REQ-022 Data outputs SHALL be 0 whenever the corresponding tag output is 0.
REQ-023 outstanding_cnt SHALL be registered and equal the popcount of valid entries after each posedge (range 0..15).

Reset
REQ-024 Reset SHALL clear all tag-table entries, set outstanding_cnt=0, and set the priority pointer to port 1.
REQ-025 Reset asserted mid-transaction SHALL make later returns of previously issued tags take the dropped path of REQ-020.
REQ-026 While reset is high, all response/tag/data outputs SHALL be 0 and proc2mem_command SHALL be BUS_NONE.

Configuration
REQ-027 With ICACHE_ARB_RR_EN defined: when both ports request distinct addresses, the pointer port wins, and the pointer toggles to the other port on each posedge where the winner was accepted (mem2proc_response != 0).
REQ-028 Without ICACHE_ARB_RR_EN: port 1 always wins conflicts, and no pointer register exists.

Structure
REQ-029 The shared package SHALL hold BUS_NONE/BUS_LOAD constants, an owner-mask typedef, and a tag-table entry typedef.
REQ-030 The tag table SHALL be a sub-module icache_arb_tag_table (alloc port, lookup/free port, count output); arbitration logic stays in icache_mem_arb.

Verification
REQ-031 Port 1 LOAD addr 0x40, mem2proc_response=3 -> proc2mem_addr=0x40, Imem2proc_response1=3, Imem2proc_response=0; 3 cycles later mem2proc_tag=3, data=0xAB -> Imem2proc_tag1=3, data1=0xAB, port 0 tag=0; outstanding_cnt goes 1 then 0.
REQ-032 Both ports LOAD (0x40, 0x80), response=5 then 6, with RR_EN -> cycle 1 issues 0x40 (port 1), cycle 2 issues 0x80 (port 0), and Imem2proc_response=6 in cycle 2.
REQ-033 Both ports LOAD 0x100, response=7 -> one issue; both responses=7; tag 7 return delivers data to both ports.
REQ-034 mem2proc_tag=9 with no entry 9 allocated -> both tag outputs 0, outstanding_cnt unchanged.
REQ-035 Allocate tag 4, assert reset one cycle, return tag 4 -> dropped, outstanding_cnt=0.
REQ-036 Same cycle: return tag 2 (owner port 0) and new port 1 request accepted with response=2 -> port 0 receives tag 2, and entry 2 ends owned by port 1 with outstanding_cnt unchanged.

Source files
------------

// File: rtl/icache_arb_pkg.sv
// Shared types for the two-port icache memory arbiter.
// Bus commands, owner masks and tag-table entry layout.
package icache_arb_pkg;

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    // bit 1 = icache port 1, bit 0 = icache port 0
    typedef logic [1:0] owner_t;

    typedef struct packed {
        owner_t owner;
    } entry_t;

    function automatic logic entry_valid(input entry_t e);
        return |e.owner;
    endfunction

endpackage

// File: rtl/icache_arb_tag_table.sv
// Outstanding-tag table: owner mask per memory tag, free on lookup hit.
// Allocation beats a same-cycle free of the same tag; entry 0 never valid.
module icache_arb_tag_table
    import icache_arb_pkg::*;
#(
    parameter int NUM_MEM_TAGS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       alloc_en_i,
    input  logic [3:0] alloc_tag_i,
    input  owner_t     alloc_owner_i,
    input  logic [3:0] lookup_tag_i,
    output owner_t     lookup_owner_o,
    output logic [4:0] count_o
);

    entry_t [NUM_MEM_TAGS-1:0] tbl_q, tbl_d;
    logic [4:0]                cnt_q, cnt_d;

    always_comb begin
        lookup_owner_o = '0;
        for (int i = 1; i < NUM_MEM_TAGS; i++) begin
            if (lookup_tag_i == 4'(i)) lookup_owner_o = tbl_q[i].owner;
        end
    end

    always_comb begin
        tbl_d = tbl_q;
        cnt_d = '0;
        for (int i = 1; i < NUM_MEM_TAGS; i++) begin
            if (lookup_tag_i == 4'(i)) tbl_d[i] = '0;
            if (alloc_en_i && alloc_tag_i == 4'(i)) tbl_d[i].owner = alloc_owner_i;
        end
        for (int i = 0; i < NUM_MEM_TAGS; i++) begin
            cnt_d = cnt_d + 5'(entry_valid(tbl_d[i]));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tbl_q <= '0;
            cnt_q <= '0;
        end else begin
            tbl_q <= tbl_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/icache_mem_arb.sv
// Two-port icache to single memory bus arbiter with tag-based return routing.
// Define ICACHE_ARB_RR_EN for round-robin conflict resolution (else port 1 wins).
module icache_mem_arb
    import icache_arb_pkg::*;
#(
    parameter int NUM_MEM_TAGS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2Imem_command1,
    input  logic [1:0]  proc2Imem_command,
    input  logic [63:0] proc2Imem_addr1,
    input  logic [63:0] proc2Imem_addr,
    output logic [3:0]  Imem2proc_response1,
    output logic [3:0]  Imem2proc_response,
    output logic [3:0]  Imem2proc_tag1,
    output logic [3:0]  Imem2proc_tag,
    output logic [63:0] Imem2proc_data1,
    output logic [63:0] Imem2proc_data,
    output logic [1:0]  proc2mem_command,
    output logic [63:0] proc2mem_addr,
    input  logic [3:0]  mem2proc_response,
    input  logic [3:0]  mem2proc_tag,
    input  logic [63:0] mem2proc_data,
    output logic [4:0]  outstanding_cnt
);

    logic   req1, req0, merge;
    logic   grant1, grant0;
    owner_t ret_owner;

    assign req1  = !reset && (proc2Imem_command1 != BUS_NONE);
    assign req0  = !reset && (proc2Imem_command != BUS_NONE);
    assign merge = req1 && req0 && (proc2Imem_addr1 == proc2Imem_addr);

`ifdef ICACHE_ARB_RR_EN
    // ptr_q high means port 1 has priority on the next conflict
    logic ptr_q, ptr_d;

    assign grant1 = req1 && (!req0 || merge || ptr_q);
    assign grant0 = req0 && (!req1 || merge || !ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if ((grant1 || grant0) && mem2proc_response != 4'd0) ptr_d = !ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) ptr_q <= 1'b1;
        else       ptr_q <= ptr_d;
    end
`else
    assign grant1 = req1;
    assign grant0 = req0 && (!req1 || merge);
`endif

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        if (grant1) begin
            proc2mem_command = proc2Imem_command1;
            proc2mem_addr    = proc2Imem_addr1;
        end else if (grant0) begin
            proc2mem_command = proc2Imem_command;
            proc2mem_addr    = proc2Imem_addr;
        end
    end

    assign Imem2proc_response1 = grant1 ? mem2proc_response : 4'd0;
    assign Imem2proc_response  = grant0 ? mem2proc_response : 4'd0;

    icache_arb_tag_table #(
        .NUM_MEM_TAGS (NUM_MEM_TAGS)
    ) u_tags (
        .clock          (clock),
        .reset          (reset),
        .alloc_en_i     ((grant1 || grant0) && mem2proc_response != 4'd0),
        .alloc_tag_i    (mem2proc_response),
        .alloc_owner_i  ({grant1, grant0}),
        .lookup_tag_i   (mem2proc_tag),
        .lookup_owner_o (ret_owner),
        .count_o        (outstanding_cnt)
    );

    // Reset gates returns so stale tags never reach the caches
    always_comb begin
        Imem2proc_tag1  = '0;
        Imem2proc_tag   = '0;
        Imem2proc_data1 = '0;
        Imem2proc_data  = '0;
        if (!reset && ret_owner[1]) begin
            Imem2proc_tag1  = mem2proc_tag;
            Imem2proc_data1 = mem2proc_data;
        end
        if (!reset && ret_owner[0]) begin
            Imem2proc_tag   = mem2proc_tag;
            Imem2proc_data  = mem2proc_data;
        end
    end

endmodule

// File: tb/tb_icache_mem_arb.sv
// Scoreboard bench for icache_mem_arb (default build: port 1 wins conflicts).
// Directed cycles push expected outputs, popped and compared each cycle.
module tb_icache_mem_arb;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] L = 2'd1;

    typedef struct {
        logic [3:0]  r1, r0;
        logic [1:0]  cmd;
        logic [63:0] addr;
        logic [3:0]  t1, t0;
        logic [63:0] d1, d0;
        logic [4:0]  cnt;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  c1 = '0, c0 = '0;
    logic [63:0] a1 = '0, a0 = '0;
    logic [3:0]  r1, r0, t1, t0;
    logic [63:0] d1, d0;
    logic [1:0]  mcmd;
    logic [63:0] maddr;
    logic [3:0]  mresp = '0, mtag = '0;
    logic [63:0] mdata = '0;
    logic [4:0]  cnt;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    always #5 clock = ~clock;

    icache_mem_arb dut (
        .clock               (clock),
        .reset               (reset),
        .proc2Imem_command1  (c1),
        .proc2Imem_command   (c0),
        .proc2Imem_addr1     (a1),
        .proc2Imem_addr      (a0),
        .Imem2proc_response1 (r1),
        .Imem2proc_response  (r0),
        .Imem2proc_tag1      (t1),
        .Imem2proc_tag       (t0),
        .Imem2proc_data1     (d1),
        .Imem2proc_data      (d0),
        .proc2mem_command    (mcmd),
        .proc2mem_addr       (maddr),
        .mem2proc_response   (mresp),
        .mem2proc_tag        (mtag),
        .mem2proc_data       (mdata),
        .outstanding_cnt     (cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ex(
        input logic [3:0] er1, input logic [3:0] er0,
        input logic [1:0] ecmd, input logic [63:0] eaddr,
        input logic [3:0] et1, input logic [63:0] ed1,
        input logic [3:0] et0, input logic [63:0] ed0,
        input logic [4:0] ecnt);
        exp_t e;
        e.r1 = er1; e.r0 = er0; e.cmd = ecmd; e.addr = eaddr;
        e.t1 = et1; e.d1 = ed1; e.t0 = et0; e.d0 = ed0; e.cnt = ecnt;
        return e;
    endfunction

    // One bus cycle: drive on negedge, compare comb outputs, then count after posedge
    task automatic cyc(input string nm,
                       input logic [1:0] ic1, input logic [63:0] ia1,
                       input logic [1:0] ic0, input logic [63:0] ia0,
                       input logic [3:0] ir, input logic [3:0] it,
                       input logic [63:0] id, input exp_t e);
        exp_t p;
        @(negedge clock);
        c1 = ic1; a1 = ia1; c0 = ic0; a0 = ia0;
        mresp = ir; mtag = it; mdata = id;
        sbq.push_back(e);
        #1;
        p = sbq.pop_front();
        check_eq({nm, ".resp1"}, 64'(r1), 64'(p.r1));
        check_eq({nm, ".resp0"}, 64'(r0), 64'(p.r0));
        check_eq({nm, ".cmd"},   64'(mcmd), 64'(p.cmd));
        check_eq({nm, ".addr"},  maddr, p.addr);
        check_eq({nm, ".tag1"},  64'(t1), 64'(p.t1));
        check_eq({nm, ".data1"}, d1, p.d1);
        check_eq({nm, ".tag0"},  64'(t0), 64'(p.t0));
        check_eq({nm, ".data0"}, d0, p.d0);
        @(posedge clock);
        #1;
        check_eq({nm, ".cnt"}, 64'(cnt), 64'(p.cnt));
    endtask

    initial begin
        // outputs quiet while reset is high, even with live requests
        cyc("rst0", L, 64'h40, L, 64'h80, 4'd3, 4'd0, 64'h0,
            ex(0, 0, N, 0, 0, 0, 0, 0, 0));
        cyc("rst1", L, 64'h40, N, 0, 4'd3, 4'd3, 64'hAB,
            ex(0, 0, N, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        cyc("p1req", L, 64'h40, N, 0, 4'd3, 4'd0, 64'h0,
            ex(3, 0, L, 64'h40, 0, 0, 0, 0, 1));
        cyc("idle0", N, 0, N, 0, 4'd0, 4'd0, 64'hDEAD,
            ex(0, 0, N, 0, 0, 0, 0, 0, 1));
        cyc("idle1", N, 0, N, 0, 4'd0, 4'd0, 64'h0,
            ex(0, 0, N, 0, 0, 0, 0, 0, 1));
        cyc("p1ret", N, 0, N, 0, 4'd0, 4'd3, 64'hAB,
            ex(0, 0, N, 0, 3, 64'hAB, 0, 0, 0));

        reset = 1'b1;
        cyc("rst2", N, 0, N, 0, 4'd0, 4'd0, 64'h0,
            ex(0, 0, N, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;

        cyc("conf1", L, 64'h40, L, 64'h80, 4'd5, 4'd0, 64'h0,
            ex(5, 0, L, 64'h40, 0, 0, 0, 0, 1));
        cyc("conf2", N, 0, L, 64'h80, 4'd6, 4'd0, 64'h0,
            ex(0, 6, L, 64'h80, 0, 0, 0, 0, 2));
        cyc("ret5", N, 0, N, 0, 4'd0, 4'd5, 64'h55,
            ex(0, 0, N, 0, 5, 64'h55, 0, 0, 1));
        cyc("ret6", N, 0, N, 0, 4'd0, 4'd6, 64'h66,
            ex(0, 0, N, 0, 0, 0, 6, 64'h66, 0));

        cyc("merge", L, 64'h100, L, 64'h100, 4'd7, 4'd0, 64'h0,
            ex(7, 7, L, 64'h100, 0, 0, 0, 0, 1));
        cyc("ret7", N, 0, N, 0, 4'd0, 4'd7, 64'h77,
            ex(0, 0, N, 0, 7, 64'h77, 7, 64'h77, 0));

        cyc("hold", N, 0, L, 64'h300, 4'd0, 4'd0, 64'h0,
            ex(0, 0, L, 64'h300, 0, 0, 0, 0, 0));
        cyc("p0req", N, 0, L, 64'h300, 4'd1, 4'd0, 64'h0,
            ex(0, 1, L, 64'h300, 0, 0, 0, 0, 1));
        cyc("drop9", N, 0, N, 0, 4'd0, 4'd9, 64'h99,
            ex(0, 0, N, 0, 0, 0, 0, 0, 1));

        cyc("realloc", L, 64'h500, N, 0, 4'd1, 4'd1, 64'h11,
            ex(1, 0, L, 64'h500, 0, 0, 1, 64'h11, 1));
        cyc("ret1b", N, 0, N, 0, 4'd0, 4'd1, 64'h22,
            ex(0, 0, N, 0, 1, 64'h22, 0, 0, 0));

        cyc("alloc4", L, 64'h40, N, 0, 4'd4, 4'd0, 64'h0,
            ex(4, 0, L, 64'h40, 0, 0, 0, 0, 1));
        reset = 1'b1;
        cyc("rst3", N, 0, N, 0, 4'd0, 4'd0, 64'h0,
            ex(0, 0, N, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        cyc("drop4", N, 0, N, 0, 4'd0, 4'd4, 64'h44,
            ex(0, 0, N, 0, 0, 0, 0, 0, 0));

        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sbq: %0d entries left, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
